// File: rtl/fp_encode_pipe.sv
// Linear-to-float encoder: 11-bit two's-complement sample -> {sign, exp[2:0], frac[3:0]}
// through a capture rank and three encode ranks. A single global enable stalls every rank.
module fp_encode_pipe #(
    parameter int STAGES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_sat
);

    // Index of the highest set bit; callers only use it when some bit above bit 3 is set.
    function automatic logic [3:0] lead_one(input logic [9:0] m);
        logic [3:0] p;
        p = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (m[i]) begin
                p = 4'(i);
            end
        end
        return p;
    endfunction

    // Valid bits for the capture rank, the two encode ranks and the output rank.
    logic [STAGES:0] vld_r;
    logic            en_s;

    logic [10:0]     data0_r;

    logic            sign1_s;
    logic            sat1_s;
    logic [9:0]      mag1_s;
    logic            sign1_r;
    logic            sat1_r;
    logic [9:0]      mag1_r;

    logic [3:0]      lead_s;
    logic [2:0]      exp2_s;
    logic [3:0]      frac2_s;
    logic            rnd2_s;
    logic            sign2_r;
    logic            sat2_r;
    logic [2:0]      exp2_r;
    logic [3:0]      frac2_r;
    logic            rnd2_r;

    logic [2:0]      exp3_s;
    logic [3:0]      frac3_s;
    logic [7:0]      out_byte_r;
    logic            out_sat_r;

    assign en_s      = !vld_r[STAGES] || out_ready;
    assign in_ready  = en_s;
    assign out_valid = vld_r[STAGES];
    assign out_byte  = out_byte_r;
    assign out_sat   = out_sat_r;

    // Stage 1: sign and magnitude; -1024 has no 10-bit magnitude and is clamped to 1023.
    always_comb begin
        sign1_s = data0_r[10];
        sat1_s  = 1'b0;
        mag1_s  = data0_r[9:0];
        if (data0_r == 11'h400) begin
            sat1_s = 1'b1;
            mag1_s = 10'h3FF;
        end else if (data0_r[10]) begin
            mag1_s = ~data0_r[9:0] + 10'd1;
        end else begin
            mag1_s = data0_r[9:0];
        end
    end

    // Stage 2: leading-one detect, four fraction bits below the hidden one, round bit below those.
    always_comb begin
        lead_s  = lead_one(mag1_r);
        exp2_s  = 3'd0;
        frac2_s = mag1_r[3:0];
        rnd2_s  = 1'b0;
        if (mag1_r < 10'd16) begin
            exp2_s  = 3'd0;
            frac2_s = mag1_r[3:0];
            rnd2_s  = 1'b0;
        end else begin
            exp2_s  = 3'(lead_s - 4'd3);
            frac2_s = 4'(mag1_r >> (lead_s - 4'd4));
            if (lead_s >= 4'd5) begin
                rnd2_s = |(mag1_r & (10'd1 << (lead_s - 4'd5)));
            end else begin
                rnd2_s = 1'b0;
            end
        end
    end

    // Stage 3: round half up; a fraction carry bumps the exponent, which tops out at 7.
    always_comb begin
        exp3_s  = exp2_r;
        frac3_s = frac2_r;
        if (rnd2_r) begin
            if (frac2_r == 4'hF) begin
                frac3_s = 4'h0;
                exp3_s  = exp2_r + 3'd1;
            end else begin
                frac3_s = frac2_r + 4'd1;
                exp3_s  = exp2_r;
            end
        end else begin
            frac3_s = frac2_r;
            exp3_s  = exp2_r;
        end
    end

    // Pipeline registers: everything advances together on en_s; data ranks load only for valid samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r      <= '0;
            data0_r    <= 11'd0;
            sign1_r    <= 1'b0;
            sat1_r     <= 1'b0;
            mag1_r     <= 10'd0;
            sign2_r    <= 1'b0;
            sat2_r     <= 1'b0;
            exp2_r     <= 3'd0;
            frac2_r    <= 4'd0;
            rnd2_r     <= 1'b0;
            out_byte_r <= 8'h00;
            out_sat_r  <= 1'b0;
        end else if (en_s) begin
            vld_r <= {vld_r[STAGES-1:0], in_valid};
            if (in_valid) begin
                data0_r <= in_data;
            end
            if (vld_r[0]) begin
                sign1_r <= sign1_s;
                sat1_r  <= sat1_s;
                mag1_r  <= mag1_s;
            end
            if (vld_r[1]) begin
                sign2_r <= sign1_r;
                sat2_r  <= sat1_r;
                exp2_r  <= exp2_s;
                frac2_r <= frac2_s;
                rnd2_r  <= rnd2_s;
            end
            if (vld_r[2]) begin
                out_byte_r <= {sign2_r, exp3_s, frac3_s};
                out_sat_r  <= sat2_r;
            end
        end
    end

endmodule
